// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulator memory with a forwarding accumulate pipeline and a handshaked drain engine.
// Optional build macro PSUM_SAT_EN: saturating per-lane add instead of wrap-around.
module psum_accum_buffer #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic                          in_first,
    input  logic [LANES*IN_WIDTH-1:0]     in_data,
    input  logic                          drain_start,
    input  logic [ADDR_WIDTH-1:0]         drain_base,
    input  logic [ADDR_WIDTH:0]           drain_count,
    input  logic                          drain_clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    out_data,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic                          out_last,
    output logic                          drain_done,
    output logic                          busy
);
    localparam int unsigned IW = LANES * IN_WIDTH;
    localparam int unsigned AW = LANES * ACC_WIDTH;
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned SW = ACC_WIDTH + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [AW-1:0] mem [DEPTH];

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic                  clear_q, clear_d;
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
    logic                  s1_first_q, s2_first_q;
    logic [IW-1:0]         s1_data_q, s2_data_q;
    logic [AW-1:0]         s1_rd_q, s1_rd_d, s2_base_q, s2_base_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  drain_done_q, drain_done_d, busy_q, busy_d;
    logic [AW-1:0]         out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

    logic                  accept_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c, mem_waddr_c;
    logic [AW-1:0]         mem_rd_c, wdata_c, mem_wdata_c;
    logic                  mem_we_c;

    // Per-lane overwrite or add of one sign-extended psum.
    function automatic logic [ACC_WIDTH-1:0] lane_op(input logic first,
                                                     input logic signed [IN_WIDTH-1:0] x,
                                                     input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] ext;
`ifdef PSUM_SAT_EN
        logic signed [SW-1:0] sum;
`endif
        ext = ACC_WIDTH'(x);
        if (first) return ext;
`ifdef PSUM_SAT_EN
        sum = SW'(acc) + SW'(ext);
        if (sum[SW-1] != sum[SW-2])
            return sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return sum[ACC_WIDTH-1:0];
`else
        return acc + ext;
`endif
    endfunction

    assign in_ready = (state_q == ST_IDLE) && !drain_start;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            wdata_c[i*ACC_WIDTH +: ACC_WIDTH] = lane_op(s2_first_q,
                                                        s2_data_q[i*IN_WIDTH +: IN_WIDTH],
                                                        s2_base_q[i*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    // Single read port shared by the accumulate pipeline and the drain engine.
    assign rd_addr_c = (state_q == ST_RD) ? ptr_q : in_addr;
    assign mem_rd_c  = mem[rd_addr_c];

    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = s2_addr_q;
        mem_wdata_c = wdata_c;
        if (!rst && s2_valid_q) begin
            mem_we_c = 1'b1;
        end else if (!rst && state_q == ST_OUT && out_ready && clear_q) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = ptr_q;
            mem_wdata_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    end

    // Read bypasses the S2 write landing on the same edge; S1 forwards from S2.
    always_comb begin
        s1_rd_d    = (s2_valid_q && s2_addr_q == in_addr) ? wdata_c : mem_rd_c;
        s2_base_d  = (s2_valid_q && s1_valid_q && s1_addr_q == s2_addr_q) ? wdata_c : s1_rd_q;
        s1_valid_d = accept_c;
        s2_valid_d = s1_valid_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        clear_d = clear_q;
        case (state_q)
            ST_IDLE: begin
                if (drain_start) begin
                    ptr_d   = drain_base;
                    rem_d   = drain_count;
                    clear_d = drain_clear;
                    state_d = (drain_count == '0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: if (!s1_valid_q && !s2_valid_q) state_d = ST_RD;
            ST_RD:    state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (rem_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
                        rem_d   = rem_q - CW'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        out_valid_d  = (state_d == ST_OUT);
        out_last_d   = (state_d == ST_OUT) && (rem_d == CW'(1));
        out_data_d   = (state_q == ST_RD) ? mem_rd_c : out_data_q;
        out_addr_d   = (state_q == ST_RD) ? ptr_q : out_addr_q;
        drain_done_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE) || s1_valid_d || s2_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            clear_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            clear_q      <= clear_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            drain_done_q <= drain_done_d;
            busy_q       <= busy_d;
        end
    end

    // Pipeline payload needs no reset; the valids qualify it.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            s1_addr_q  <= in_addr;
            s1_first_q <= in_first;
            s1_data_q  <= in_data;
            s1_rd_q    <= s1_rd_d;
        end
        s2_addr_q  <= s1_addr_q;
        s2_first_q <= s1_first_q;
        s2_data_q  <= s1_data_q;
        s2_base_q  <= s2_base_d;
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign drain_done = drain_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: drivers queue expected drain words, a monitor compares them.
module tb_psum_accum_buffer;
    localparam int unsigned LANES = 16;
    localparam int unsigned IW    = 24;
    localparam int unsigned AW    = 32;
    localparam int unsigned AD    = 10;

    typedef struct {
        logic [LANES*AW-1:0] data;
        logic [AD-1:0]       addr;
        logic                last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready, in_first;
    logic [AD-1:0]       in_addr;
    logic [LANES*IW-1:0] in_data;
    logic                drain_start, drain_clear;
    logic [AD-1:0]       drain_base;
    logic [AD:0]         drain_count;
    logic                out_valid, out_ready, out_last, drain_done, busy;
    logic [LANES*AW-1:0] out_data;
    logic [AD-1:0]       out_addr;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic tog = 1'b0;

    psum_accum_buffer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_first(in_first),
        .in_data(in_data),
        .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
        .drain_clear(drain_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .drain_done(drain_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LANES*AW-1:0] act, input logic [LANES*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*IW-1:0] in_w(input logic [IW-1:0] v);
        logic [LANES*IW-1:0] w = '0;
        w[IW-1:0] = v;
        return w;
    endfunction

    function automatic logic [LANES*IW-1:0] in_all(input logic [IW-1:0] v);
        logic [LANES*IW-1:0] w;
        for (int i = 0; i < int'(LANES); i++) w[i*IW +: IW] = v;
        return w;
    endfunction

    function automatic logic [LANES*AW-1:0] acc_w(input logic [AW-1:0] v);
        logic [LANES*AW-1:0] w = '0;
        w[AW-1:0] = v;
        return w;
    endfunction

    function automatic logic [LANES*AW-1:0] acc_all(input logic [AW-1:0] v);
        logic [LANES*AW-1:0] w;
        for (int i = 0; i < int'(LANES); i++) w[i*AW +: AW] = v;
        return w;
    endfunction

    task automatic push(input logic [LANES*AW-1:0] d, input logic [AD-1:0] a, input logic l);
        exp_t e;
        e.data = d; e.addr = a; e.last = l;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [AD-1:0] a, input logic f, input logic [LANES*IW-1:0] d);
        in_valid = 1'b1; in_addr = a; in_first = f; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic [AD-1:0] b, input logic [AD:0] c, input logic clr);
        drain_start = 1'b1; drain_base = b; drain_count = c; drain_clear = clr;
        @(posedge clk); #1;
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (drain_done) begin seen = 1'b1; break; end
        end
        chk({name, "_done"}, seen, 1);
        if (seen) begin
            @(negedge clk);
            chk({name, "_done_pulse"}, drain_done, 0);
        end
        chk({name, "_sb_empty"}, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: every presented word must match the head of the scoreboard, stalled or not.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got word at addr %0d, required no output", out_addr);
            end else begin
                chk("out_data", out_data, sb[0].data);
                chk("out_addr", out_addr, sb[0].addr);
                chk("out_last", out_last, sb[0].last);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (tog) out_ready = ~out_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] sat_exp;
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_first = 1'b0; in_data = '0;
        drain_start = 1'b0; drain_base = '0; drain_count = '0; drain_clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // overwrite then add at the same address on consecutive cycles
        beat(10'd5, 1'b1, in_w(24'd10));
        beat(10'd5, 1'b0, in_w(24'hFFFFFD));
        push(acc_w(32'd7), 10'd5, 1'b1);
        drain(10'd5, 11'd1, 1'b0);
        wait_done("t1");

        // four back-to-back adds to a zeroed word
        beat(10'd9, 1'b1, '0);
        for (int i = 0; i < 4; i++) beat(10'd9, 1'b0, in_all(24'd1));
        push(acc_all(32'd4), 10'd9, 1'b1);
        drain(10'd9, 11'd1, 1'b0);
        wait_done("t2");

        // wrap across the top of the address space with a stalling sink
        beat(10'd1022, 1'b1, in_w(24'd1));
        beat(10'd1023, 1'b1, in_w(24'd2));
        beat(10'd0, 1'b1, in_w(24'd3));
        push(acc_w(32'd1), 10'd1022, 1'b0);
        push(acc_w(32'd2), 10'd1023, 1'b0);
        push(acc_w(32'd3), 10'd0, 1'b1);
        tog = 1'b1;
        drain(10'd1022, 11'd3, 1'b0);
        wait_done("t3");
        tog = 1'b0; out_ready = 1'b1;

        // clearing drain, then re-drain sees zeros; then an empty drain
        push(acc_w(32'd1), 10'd1022, 1'b0);
        push(acc_w(32'd2), 10'd1023, 1'b1);
        drain(10'd1022, 11'd2, 1'b1);
        wait_done("t4a");
        push('0, 10'd1022, 1'b0);
        push('0, 10'd1023, 1'b1);
        drain(10'd1022, 11'd2, 1'b0);
        wait_done("t4b");
        drain(10'd0, 11'd0, 1'b0);
        @(negedge clk);
        chk("t4_empty_done", drain_done, 1);
        @(negedge clk);
        chk("t4_empty_done_pulse", drain_done, 0);
        @(posedge clk); #1;

        // 256*(2^23-1) + 255 = 2^31-1, then +5 overflows
        beat(10'd300, 1'b1, in_w(24'h7FFFFF));
        for (int i = 0; i < 255; i++) beat(10'd300, 1'b0, in_w(24'h7FFFFF));
        beat(10'd300, 1'b0, in_w(24'd255));
        beat(10'd300, 1'b0, in_w(24'd5));
`ifdef PSUM_SAT_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = 32'h80000004;
`endif
        push(acc_w(sat_exp), 10'd300, 1'b1);
        drain(10'd300, 11'd1, 1'b0);
        wait_done("t5");

        // reset while stalled in OUT aborts the drain
        out_ready = 1'b0;
        push('0, 10'd1022, 1'b0);
        push('0, 10'd1023, 1'b1);
        drain(10'd1022, 11'd2, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t6_stalled_valid", out_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;

        // drain_start wins over a same-cycle beat
        beat(10'd200, 1'b1, in_w(24'd50));
        repeat (3) @(posedge clk);
        #1;
        push(acc_w(32'd50), 10'd200, 1'b1);
        drain_start = 1'b1; drain_base = 10'd200; drain_count = 11'd1; drain_clear = 1'b0;
        in_valid = 1'b1; in_addr = 10'd200; in_first = 1'b1; in_data = in_w(24'd99);
        #1 chk("t6_in_ready_drain", in_ready, 0);
        @(posedge clk); #1;
        drain_start = 1'b0; in_valid = 1'b0;
        wait_done("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
